// File: rtl/mmio_interconnect.sv
// mmio_interconnect: single-outstanding MMIO router from one CPU port to
// NUM_SLAVES slaves, decoded on cpu_addr[31:24], with exec-permission check,
// per-access timeout and a sticky first-error status.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_valid, cpu_instr       CPU request strobe / instruction-fetch flag
//   cpu_addr, cpu_wdata        request address / write data
//   cpu_wstrb                  byte strobes (0 = read)
//   cpu_ready, cpu_rdata       one-cycle completion pulse / response data
//   force_trap                 forces an error response for the sampled request
//   slv_cs                     one-hot slave select, high only while accessing
//   slv_addr/wdata/wstrb       request fields latched at acceptance
//   slv_rdata, slv_ready       per-slave read data (32 bits each) / ready
//   err_clear                  clears the sticky error status
//   err_flag, err_cause        sticky error flag / cause (0 trap,1 miss,2 exec,3 timeout)
//   err_addr                   address of the first recorded error
module mmio_interconnect #(
  parameter int unsigned                 NUM_SLAVES     = 4,
  parameter logic [8*NUM_SLAVES-1:0]     SLAVE_PREFIXES = {8'hC3, 8'hC2, 8'hC1, 8'hC0},
  parameter logic [NUM_SLAVES-1:0]       EXEC_MASK      = 4'b0011,
  parameter logic [15:0]                 TIMEOUT        = 16'd255,
  parameter logic [31:0]                 ERR_RDATA      = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_valid,
  input  logic                       cpu_instr,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic [3:0]                 cpu_wstrb,
  output logic                       cpu_ready,
  output logic [31:0]                cpu_rdata,
  input  logic                       force_trap,
  output logic [NUM_SLAVES-1:0]      slv_cs,
  output logic [31:0]                slv_addr,
  output logic [31:0]                slv_wdata,
  output logic [3:0]                 slv_wstrb,
  input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  input  logic                       err_clear,
  output logic                       err_flag,
  output logic [1:0]                 err_cause,
  output logic [31:0]                err_addr
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] CAUSE_TRAP    = 2'd0;
  localparam logic [1:0] CAUSE_MISS    = 2'd1;
  localparam logic [1:0] CAUSE_EXEC    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state, state_nxt;
  logic [SEL_W-1:0]       sel, sel_nxt;
  logic [15:0]            cnt, cnt_nxt;
  logic [NUM_SLAVES-1:0]  cs_nxt;
  logic [31:0]            addr_nxt, wdata_nxt, rdata_nxt;
  logic [3:0]             wstrb_nxt;
  logic                   ready_nxt;
  logic                   flag_nxt;
  logic [1:0]             cause_nxt;
  logic [31:0]            eaddr_nxt;

  // Address decode; scanning high to low lets the lowest matching index win.
  logic                   dec_hit;
  logic                   dec_exec;
  logic [SEL_W-1:0]       dec_sel;
  logic [NUM_SLAVES-1:0]  dec_onehot;

  always_comb begin
    dec_hit    = 1'b0;
    dec_exec   = 1'b0;
    dec_sel    = '0;
    dec_onehot = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (cpu_addr[31:24] == SLAVE_PREFIXES[8*i +: 8]) begin
        dec_hit       = 1'b1;
        dec_exec      = EXEC_MASK[i];
        dec_sel       = SEL_W'(i);
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
      end
    end
  end

  // Response mux for the slave selected by the in-flight transaction.
  logic        sel_ready;
  logic [31:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

  // Next-state and next-output logic.
  logic        err_evt;
  logic [1:0]  err_code;
  logic [31:0] err_at;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    cs_nxt    = '0;
    addr_nxt  = slv_addr;
    wdata_nxt = slv_wdata;
    wstrb_nxt = slv_wstrb;
    rdata_nxt = cpu_rdata;
    ready_nxt = 1'b0;
    err_evt   = 1'b0;
    err_code  = CAUSE_TRAP;
    err_at    = slv_addr;
    flag_nxt  = err_flag;
    cause_nxt = err_cause;
    eaddr_nxt = err_addr;

    unique case (state)
      IDLE: begin
        if (cpu_valid) begin
          addr_nxt  = cpu_addr;
          wdata_nxt = cpu_wdata;
          wstrb_nxt = cpu_wstrb;
          err_at    = cpu_addr;
          if (force_trap || !dec_hit || (cpu_instr && !dec_exec)) begin
            err_evt   = 1'b1;
            err_code  = force_trap ? CAUSE_TRAP :
                        !dec_hit   ? CAUSE_MISS : CAUSE_EXEC;
            rdata_nxt = ERR_RDATA;
            ready_nxt = 1'b1;
            state_nxt = RESP;
          end else begin
            sel_nxt   = dec_sel;
            cnt_nxt   = '0;
            cs_nxt    = dec_onehot;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          rdata_nxt = sel_rdata;
          ready_nxt = 1'b1;
          state_nxt = RESP;
        end else if (cnt == TIMEOUT - 16'd1) begin
          err_evt   = 1'b1;
          err_code  = CAUSE_TIMEOUT;
          rdata_nxt = ERR_RDATA;
          ready_nxt = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 16'd1;
          cs_nxt  = slv_cs;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Sticky status: first error kept, but a clear in the same cycle lets the new one in.
    if (err_clear) flag_nxt = 1'b0;
    if (err_evt && (!err_flag || err_clear)) begin
      flag_nxt  = 1'b1;
      cause_nxt = err_code;
      eaddr_nxt = err_at;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      slv_cs    <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      slv_wstrb <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      err_flag  <= 1'b0;
      err_cause <= '0;
      err_addr  <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      cnt       <= cnt_nxt;
      slv_cs    <= cs_nxt;
      slv_addr  <= addr_nxt;
      slv_wdata <= wdata_nxt;
      slv_wstrb <= wstrb_nxt;
      cpu_rdata <= rdata_nxt;
      cpu_ready <= ready_nxt;
      err_flag  <= flag_nxt;
      err_cause <= cause_nxt;
      err_addr  <= eaddr_nxt;
    end
  end

endmodule

// File: tb/tb_mmio_interconnect.sv
// Directed self-checking bench for mmio_interconnect: default instance plus a
// small alternate instance with overlapping prefixes and a short timeout.
module tb_mmio_interconnect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_instr, force_trap, err_clear;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;

  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [3:0]  slv_cs;
  logic [31:0] slv_addr, slv_wdata;
  logic [3:0]  slv_wstrb;
  logic [127:0] slv_rdata;
  logic [3:0]  slv_ready;
  logic        err_flag;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  logic        a_cpu_ready;
  logic [31:0] a_cpu_rdata;
  logic [1:0]  a_slv_cs;
  logic [31:0] a_slv_addr, a_slv_wdata;
  logic [3:0]  a_slv_wstrb;
  logic [63:0] a_slv_rdata;
  logic [1:0]  a_slv_ready;
  logic        a_err_flag;
  logic [1:0]  a_err_cause;
  logic [31:0] a_err_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mmio_interconnect dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .force_trap(force_trap),
    .slv_cs(slv_cs), .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_rdata(slv_rdata), .slv_ready(slv_ready), .err_clear(err_clear),
    .err_flag(err_flag), .err_cause(err_cause), .err_addr(err_addr)
  );

  // Both slaves answer to 0xA0; exec is allowed only on slave 1.
  mmio_interconnect #(
    .NUM_SLAVES(2), .SLAVE_PREFIXES({8'hA0, 8'hA0}), .EXEC_MASK(2'b10),
    .TIMEOUT(16'd3), .ERR_RDATA(32'hBAD0BAD0)
  ) alt (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(a_cpu_ready), .cpu_rdata(a_cpu_rdata), .force_trap(force_trap),
    .slv_cs(a_slv_cs), .slv_addr(a_slv_addr), .slv_wdata(a_slv_wdata), .slv_wstrb(a_slv_wstrb),
    .slv_rdata(a_slv_rdata), .slv_ready(a_slv_ready), .err_clear(err_clear),
    .err_flag(a_err_flag), .err_cause(a_err_cause), .err_addr(a_err_addr)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL rst_ready: got %h want 0", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (slv_cs !== 4'h0) $display("FAIL rst_cs: got %h want 0", slv_cs); else n_pass++;
    n_total++; if (slv_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", slv_addr); else n_pass++;
    n_total++; if (slv_wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", slv_wdata); else n_pass++;
    n_total++; if (slv_wstrb !== 4'h0) $display("FAIL rst_wstrb: got %h want 0", slv_wstrb); else n_pass++;
    n_total++; if (err_flag !== 1'b0) $display("FAIL rst_flag: got %h want 0", err_flag); else n_pass++;
    n_total++; if (err_cause !== 2'd0) $display("FAIL rst_cause: got %h want 0", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'h0) $display("FAIL rst_eaddr: got %h want 0", err_addr); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    slv_ready = 4'b0010;
    slv_rdata[63:32] = 32'hDEADBEEF;
    cpu_valid = 1'b1; cpu_addr = 32'hC1000008; cpu_wstrb = 4'h0; cpu_wdata = 32'h55;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'b0010) $display("FAIL read_cs: got %b want 0010", slv_cs); else n_pass++;
    n_total++; if (slv_addr !== 32'hC1000008) $display("FAIL read_addr: got %h want c1000008", slv_addr); else n_pass++;
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL read_early_ready: got %h want 0", cpu_ready); else n_pass++;
    cpu_valid = 1'b0; cpu_addr = 32'h0;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL read_ready: got %h want 1", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL read_rdata: got %h want deadbeef", cpu_rdata); else n_pass++;
    n_total++; if (slv_cs !== 4'h0) $display("FAIL read_cs_resp: got %b want 0000", slv_cs); else n_pass++;
    slv_ready = 4'h0;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL read_pulse: got %h want 0", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL read_hold: got %h want deadbeef", cpu_rdata); else n_pass++;
  endtask

  task automatic test_exec_violation();
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'hC2000000;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'h0) $display("FAIL exec_cs: got %b want 0000", slv_cs); else n_pass++;
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL exec_ready: got %h want 1", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL exec_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (err_flag !== 1'b1) $display("FAIL exec_flag: got %h want 1", err_flag); else n_pass++;
    n_total++; if (err_cause !== 2'd2) $display("FAIL exec_cause: got %h want 2", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'hC2000000) $display("FAIL exec_eaddr: got %h want c2000000", err_addr); else n_pass++;
    cpu_valid = 1'b0; cpu_instr = 1'b0;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL exec_pulse: got %h want 0", cpu_ready); else n_pass++;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    n_total++; if (err_flag !== 1'b0) $display("FAIL exec_clear: got %h want 0", err_flag); else n_pass++;
  endtask

  task automatic test_timeout();
    int cyc;
    slv_ready = 4'h0;
    cpu_valid = 1'b1; cpu_addr = 32'hC3000000; cpu_wdata = 32'hA5A5A5A5; cpu_wstrb = 4'hF;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'b1000) $display("FAIL to_cs: got %b want 1000", slv_cs); else n_pass++;
    n_total++; if (slv_wstrb !== 4'hF) $display("FAIL to_wstrb: got %h want f", slv_wstrb); else n_pass++;
    n_total++; if (slv_wdata !== 32'hA5A5A5A5) $display("FAIL to_wdata: got %h want a5a5a5a5", slv_wdata); else n_pass++;
    cpu_valid = 1'b0; cpu_addr = 32'hC0000000; cpu_wstrb = 4'h0;
    cyc = 0;
    while (slv_cs[3] === 1'b1 && cpu_ready !== 1'b1 && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (cyc != 255) $display("FAIL to_cycles: got %0d want 255", cyc); else n_pass++;
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL to_ready: got %h want 1", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL to_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (err_cause !== 2'd3) $display("FAIL to_cause: got %h want 3", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'hC3000000) $display("FAIL to_eaddr: got %h want c3000000", err_addr); else n_pass++;
    n_total++; if (slv_addr !== 32'hC3000000) $display("FAIL to_addr_held: got %h want c3000000", slv_addr); else n_pass++;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL to_pulse: got %h want 0", cpu_ready); else n_pass++;
  endtask

  task automatic test_miss_after_error();
    cpu_valid = 1'b1; cpu_addr = 32'h40000000;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL miss_ready: got %h want 1", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL miss_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (err_cause !== 2'd3) $display("FAIL miss_keep_cause: got %h want 3", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'hC3000000) $display("FAIL miss_keep_eaddr: got %h want c3000000", err_addr); else n_pass++;
    cpu_valid = 1'b0;
    @(negedge clk);
    cpu_valid = 1'b1; err_clear = 1'b1;
    @(negedge clk);
    n_total++; if (err_flag !== 1'b1) $display("FAIL clrmiss_flag: got %h want 1", err_flag); else n_pass++;
    n_total++; if (err_cause !== 2'd1) $display("FAIL clrmiss_cause: got %h want 1", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'h40000000) $display("FAIL clrmiss_eaddr: got %h want 40000000", err_addr); else n_pass++;
    cpu_valid = 1'b0; err_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_force_trap();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    slv_ready = 4'b0001; slv_rdata[31:0] = 32'hCAFEF00D;
    force_trap = 1'b1; cpu_valid = 1'b1; cpu_addr = 32'hC0000000;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'h0) $display("FAIL trap_cs: got %b want 0000", slv_cs); else n_pass++;
    n_total++; if (cpu_ready !== 1'b1) $display("FAIL trap_ready: got %h want 1", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL trap_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (err_flag !== 1'b1) $display("FAIL trap_flag: got %h want 1", err_flag); else n_pass++;
    n_total++; if (err_cause !== 2'd0) $display("FAIL trap_cause: got %h want 0", err_cause); else n_pass++;
    n_total++; if (err_addr !== 32'hC0000000) $display("FAIL trap_eaddr: got %h want c0000000", err_addr); else n_pass++;
    force_trap = 1'b0; cpu_valid = 1'b0; slv_ready = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_alt_overlap_timeout();
    int cyc;
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    n_total++; if (a_err_flag !== 1'b0) $display("FAIL alt_clear0: got %h want 0", a_err_flag); else n_pass++;
    // Lowest index (slave 0, not executable) must win the overlap.
    cpu_valid = 1'b1; cpu_instr = 1'b1; cpu_addr = 32'hA0000000;
    @(negedge clk);
    n_total++; if (a_slv_cs !== 2'b00) $display("FAIL alt_exec_cs: got %b want 00", a_slv_cs); else n_pass++;
    n_total++; if (a_err_cause !== 2'd2) $display("FAIL alt_exec_cause: got %h want 2", a_err_cause); else n_pass++;
    n_total++; if (a_cpu_rdata !== 32'hBAD0BAD0) $display("FAIL alt_exec_rdata: got %h want bad0bad0", a_cpu_rdata); else n_pass++;
    cpu_valid = 1'b0; cpu_instr = 1'b0; err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    n_total++; if (a_err_flag !== 1'b0) $display("FAIL alt_clear1: got %h want 0", a_err_flag); else n_pass++;
    // Ready arriving in the last permitted cycle is a success; unselected ready ignored.
    a_slv_rdata = {32'h22222222, 32'h11111111};
    a_slv_ready = 2'b10;
    cpu_valid = 1'b1; cpu_addr = 32'hA0000004;
    @(negedge clk);
    n_total++; if (a_slv_cs !== 2'b01) $display("FAIL alt_cs1: got %b want 01", a_slv_cs); else n_pass++;
    cpu_valid = 1'b0;
    @(negedge clk);
    n_total++; if (a_slv_cs !== 2'b01) $display("FAIL alt_cs2: got %b want 01", a_slv_cs); else n_pass++;
    @(negedge clk);
    n_total++; if (a_slv_cs !== 2'b01) $display("FAIL alt_cs3: got %b want 01", a_slv_cs); else n_pass++;
    a_slv_ready = 2'b01;
    @(negedge clk);
    n_total++; if (a_cpu_ready !== 1'b1) $display("FAIL alt_last_ready: got %h want 1", a_cpu_ready); else n_pass++;
    n_total++; if (a_cpu_rdata !== 32'h11111111) $display("FAIL alt_last_rdata: got %h want 11111111", a_cpu_rdata); else n_pass++;
    n_total++; if (a_err_flag !== 1'b0) $display("FAIL alt_last_flag: got %h want 0", a_err_flag); else n_pass++;
    a_slv_ready = 2'b00;
    @(negedge clk);
    // Short timeout: exactly three ACCESS cycles.
    cpu_valid = 1'b1; cpu_addr = 32'hA0000000;
    @(negedge clk);
    cpu_valid = 1'b0;
    cyc = 0;
    while (a_slv_cs[0] === 1'b1 && a_cpu_ready !== 1'b1 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    n_total++; if (cyc != 3) $display("FAIL alt_to_cycles: got %0d want 3", cyc); else n_pass++;
    n_total++; if (a_cpu_ready !== 1'b1) $display("FAIL alt_to_ready: got %h want 1", a_cpu_ready); else n_pass++;
    n_total++; if (a_cpu_rdata !== 32'hBAD0BAD0) $display("FAIL alt_to_rdata: got %h want bad0bad0", a_cpu_rdata); else n_pass++;
    n_total++; if (a_err_cause !== 2'd3) $display("FAIL alt_to_cause: got %h want 3", a_err_cause); else n_pass++;
    n_total++; if (a_err_addr !== 32'hA0000000) $display("FAIL alt_to_eaddr: got %h want a0000000", a_err_addr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    slv_ready = 4'b0100; slv_rdata[95:64] = 32'h12345678;
    cpu_valid = 1'b1; cpu_addr = 32'hC2000010; cpu_wstrb = 4'h3; cpu_wdata = 32'h0F0F0F0F;
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    n_total++; if (cpu_rdata !== 32'h12345678) $display("FAIL rmid_pre_rdata: got %h want 12345678", cpu_rdata); else n_pass++;
    slv_ready = 4'h0;
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'hC2000020;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'b0100) $display("FAIL rmid_cs: got %b want 0100", slv_cs); else n_pass++;
    cpu_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (slv_cs !== 4'h0) $display("FAIL rmid_cs0: got %b want 0000", slv_cs); else n_pass++;
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL rmid_ready: got %h want 0", cpu_ready); else n_pass++;
    n_total++; if (cpu_rdata !== 32'h0) $display("FAIL rmid_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_total++; if (slv_addr !== 32'h0) $display("FAIL rmid_addr: got %h want 0", slv_addr); else n_pass++;
    n_total++; if (slv_wstrb !== 4'h0) $display("FAIL rmid_wstrb: got %h want 0", slv_wstrb); else n_pass++;
    n_total++; if (err_flag !== 1'b0) $display("FAIL rmid_flag: got %h want 0", err_flag); else n_pass++;
    n_total++; if (err_addr !== 32'h0) $display("FAIL rmid_eaddr: got %h want 0", err_addr); else n_pass++;
    slv_ready = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (cpu_ready !== 1'b0) $display("FAIL rmid_no_pulse: got %h want 0", cpu_ready); else n_pass++;
    n_total++; if (slv_cs !== 4'h0) $display("FAIL rmid_idle_cs: got %b want 0000", slv_cs); else n_pass++;
    slv_ready = 4'h0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_instr = 1'b0; force_trap = 1'b0; err_clear = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    slv_rdata = '0; slv_ready = '0; a_slv_rdata = '0; a_slv_ready = '0;
    test_reset();
    test_read_hit();
    test_exec_violation();
    test_timeout();
    test_miss_after_error();
    test_force_trap();
    test_alt_overlap_timeout();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmio_interconnect.md
MMIO_INTERCONNECT -- requirements
Module: mmio_interconnect

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal range 1..16).
REQ-002 The block SHALL have parameter SLAVE_PREFIXES, default {8'hC3,8'hC2,8'hC1,8'hC0}, per-slave cpu_addr[31:24] match value; slave i at bits [8i+7:8i].
REQ-003 The block SHALL have parameter EXEC_MASK, default 4'b0011, where bit i=1 permits instruction fetch from slave i.
REQ-004 The block SHALL have parameter TIMEOUT, default 16'd255, the maximum number of ACCESS cycles before the access is aborted (legal range 1..65535).
REQ-005 The block SHALL have parameter ERR_RDATA, default 32'h0, the read data returned on any error response (value 32'h0 is the illegal instruction).
REQ-006 The block SHALL have port clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit; reset is rst_n, synchronous, active-low; the clock is clk.
REQ-008 The block SHALL have port cpu_valid, input, 1 bit, CPU request.
REQ-009 The block SHALL have port cpu_instr, input, 1 bit, request is an instruction fetch.
REQ-010 The block SHALL have ports cpu_addr, input, 32 bits; cpu_wdata, input, 32 bits; and cpu_wstrb, input, 4 bits (0 = read).
REQ-011 The block SHALL have port cpu_ready, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port cpu_rdata, output, 32 bits, response data.
REQ-013 The block SHALL have port force_trap, input, 1 bit, which forces an error response.
REQ-014 The block SHALL have ports slv_cs, output, NUM_SLAVES bits, one-hot select; slv_addr, output, 32 bits; slv_wdata, output, 32 bits; and slv_wstrb, output, 4 bits, latched request fields.
REQ-015 The block SHALL have ports slv_rdata, input, 32*NUM_SLAVES bits (slave i at [32i+31:32i]), and slv_ready, input, NUM_SLAVES bits.
REQ-016 The block SHALL have port err_clear, input, 1 bit, which clears the error status.
REQ-017 The block SHALL have ports err_flag, output, 1 bit, sticky error; err_cause, output, 2 bits; and err_addr, output, 32 bits, the address of the first error.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP, with one transaction in flight at a time.
REQ-019 In IDLE with cpu_valid=1, the block SHALL latch addr/wdata/wstrb/instr into slv_addr/slv_wdata/slv_wstrb and classify the request by priority: force_trap; then decode miss (no prefix match); then exec violation (cpu_instr=1, EXEC_MASK[sel]=0); otherwise hit.
REQ-020 When several prefixes match, the lowest slave index SHALL win.
REQ-021 On a hit, the FSM SHALL go IDLE->ACCESS, store sel, and clear the timeout counter; on any other class it SHALL go IDLE->RESP with cpu_rdata=ERR_RDATA.
REQ-022 In ACCESS, slv_cs[sel] SHALL be 1 and all other bits 0; slv_cs SHALL be all-zero in IDLE and RESP.
REQ-023 In ACCESS, when slv_ready[sel]=1, the block SHALL capture slv_rdata[sel] into cpu_rdata and go to RESP; slv_ready from unselected slaves SHALL be ignored.
REQ-024 The counter SHALL increment every ACCESS cycle without ready; if ready is still absent in the TIMEOUT-th ACCESS cycle, the FSM SHALL go to RESP with ERR_RDATA; ready in that same cycle counts as success.
REQ-025 In RESP, cpu_ready SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE; cpu_valid SHALL NOT be sampled in RESP.
REQ-026 Latency SHALL be: hit with zero-wait slave, cpu_ready 2 cycles after the cpu_valid sampling edge; error class, 1 cycle.
REQ-027 cpu_rdata SHALL hold its value until the next response.
REQ-028 Changes to cpu_valid or cpu_addr during ACCESS SHALL be ignored; the transaction completes.
REQ-029 err_cause SHALL be encoded as: 0 force_trap, 1 decode miss, 2 exec violation, 3 timeout.
REQ-030 On an error, if err_flag=0, the block SHALL set err_flag and load err_cause and err_addr; if err_flag=1, it SHALL leave them unchanged (first error kept).
REQ-031 err_clear SHALL clear err_flag; if a new error occurs in the same cycle, the new error SHALL win (flag stays set with the new cause and address).

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL go to IDLE, with cpu_ready=0, cpu_rdata=0, slv_cs=0, slv_addr/slv_wdata/slv_wstrb=0, counter=0, err_flag=0, err_cause=0 and err_addr=0.
REQ-033 Reset during ACCESS or RESP SHALL abort the transaction with no cpu_ready pulse.

Verification
REQ-034 Read of 0xC1000008, slv_ready[1]=1 immediately with rdata 0xDEADBEEF -> slv_cs=4'b0010 for 1 cycle, then cpu_ready pulse with cpu_rdata=0xDEADBEEF.
REQ-035 Fetch from 0xC2000000 -> no slv_cs, cpu_ready after 1 cycle, cpu_rdata=0, err_flag=1, err_cause=2, err_addr=0xC2000000.
REQ-036 Write to 0xC3000000 with wstrb=4'hF, slave 3 never ready, TIMEOUT=255 -> slv_cs[3] high for 255 cycles, then cpu_ready with cpu_rdata=0 and err_cause=3.
REQ-037 Access to 0x40000000 following an earlier timeout -> cpu_rdata=0, err_cause stays 3; err_clear and a miss in the same cycle -> err_flag=1, err_cause=1, err_addr=0x40000000.
REQ-038 force_trap=1 together with a valid hit on 0xC0000000 -> no slv_cs, err_cause=0.
REQ-039 rst_n=0 mid-ACCESS -> slv_cs=0 the next cycle, no cpu_ready, all outputs at their reset values.
